parking_lot_multi_gate: RTL and testbench
=========================================

// Module: parking_lot_multi_gate
// PURPOSE
//  Multi-gate occupancy tracker for the parking-lot lab.
//  - Each of NUM_GATES gates has an outer/inner photo-sensor pair and its own FSM that decodes entries and exits.
//  - A shared saturating occupancy counter tracks cars and drives full/clear flags for the HEX/LED display logic.
//  - Sits between the GPIO sensor inputs and the display/top-level DE1_SoC logic.
// PARAMETERS
//  NUM_GATES  2   number of independent gates (1..8)
//  CAPACITY   16  lot capacity; count saturates here
//  CNT_W      $clog2(CAPACITY+1)  count width (derived, do not override)
// PORTS
//  clk          in   1          system clock (CLOCK_50 domain)
//  reset        in   1          synchronous, active-high reset
//  outer        in   NUM_GATES  outer sensor per gate, 1 = beam blocked
//  inner        in   NUM_GATES  inner sensor per gate, 1 = beam blocked
//  enter_pulse  out  NUM_GATES  1-cycle pulse per completed entry
//  exit_pulse   out  NUM_GATES  1-cycle pulse per completed exit
//  count        out  CNT_W      current occupancy
//  full         out  1          count == CAPACITY
//  clear        out  1          count == 0
//  overflow     out  1          sticky: an entry was dropped at CAPACITY
//  underflow    out  1          sticky: an exit was dropped at 0
// BEHAVIOUR
//  Reset (sync, high at posedge):
//  - All FSMs go to IDLE; count=0, all pulses=0, overflow=underflow=0.
//  - full=0, clear=1 after reset (CAPACITY>=1).
//  - Reset mid-sequence abandons the sequence with no pulse.
//  Per-gate FSM, input pair p={outer,inner} sampled every posedge:
//  - IDLE: 10->E1; 01->X1; 11->WAIT; 00->IDLE
//  - E1 (10): 11->E2; 00->IDLE; 10 stay; 01->WAIT
//  - E2 (11): 01->E3; 10->E1 (backed out); 11 stay; 00->WAIT->IDLE path (see WAIT)
//  - E3 (01): 00->IDLE + enter_pulse; 11->E2; 01 stay; 10->WAIT
//  - X1 (01): 11->X2; 00->IDLE; 01 stay; 10->WAIT
//  - X2 (11): 10->X3; 01->X1; 11 stay; 00->WAIT
//  - X3 (10): 00->IDLE + exit_pulse; 11->X2; 10 stay; 01->WAIT
//  - WAIT: stays until p==00, then IDLE; never emits a pulse
//  - Only E3->IDLE and X3->IDLE emit events. All other returns to IDLE are silent aborts.
//  Pulse timing:
//  - Pulses are registered. If the edge k sample completes a sequence, the pulse is high for exactly the cycle after edge k.
//  Counter:
//  - At edge k+1, net = popcount(enter_pulse) - popcount(exit_pulse), computed signed with width CNT_W+$clog2(NUM_GATES+1)+1.
//  - count <= clamp(count+net, 0, CAPACITY).
//  - Clamp high sets overflow (sticky); clamp low sets underflow (sticky). Only reset clears them.
//  - Net count latency from the completing sample: 2 edges.
//  Flags and simultaneous events:
//  - full/clear are combinational decodes of the count register.
//  - Simultaneous entry and exit on any gates net out. E.g. count=CAPACITY with enter g0 + exit g1 -> count unchanged, no overflow.
//  - Gates are fully independent; one gate's abort never affects another.
// CONFIGURATION
//  PARKING_SYNC_EN
//  - Defined: outer/inner each pass through a 2-flop synchronizer (reset to 0) before the FSM.
//  - Defined: every latency above grows by 2 cycles.
//  - Undefined: the FSM samples outer/inner directly, and the inputs must already be synchronous to clk.
// TESTING  (NUM_GATES=2, CAPACITY=4, macro undefined unless noted)
//  1. Reset, then g0 drives 10,11,01,00 (1 cycle each).
//     -> enter_pulse[0] high 1 cycle after the 00 sample; count=1 one cycle later; clear 1->0.
//  2. Five full entries on g1.
//     -> count reaches 4, full=1; 5th pulse still fires, count stays 4, overflow=1 until reset.
//  3. count=2; g0 entry and g1 exit complete on the same cycle.
//     -> both pulses high together, count stays 2, no overflow/underflow.
//  4. g0 drives 10,11,10,00 (backed out).
//     -> no pulse, count unchanged; then 10,01,00 -> WAIT, no pulse.
//  5. Reset asserted while g0 is in E2; release; g0 drives 01,00.
//     -> FSM goes IDLE->X1->IDLE silently, count=0, no pulses.
//  6. PARKING_SYNC_EN defined, repeat test 1.
//     -> enter_pulse arrives exactly 2 cycles later than without the macro.

Source files
------------

// File: rtl/parking_lot_multi_gate.sv
// rtl/parking_lot_multi_gate.sv - multi-gate parking-lot occupancy tracker
// Purpose:
//   Each gate has an outer/inner photo-sensor pair decoded by its own FSM into
//   entry/exit events. A shared saturating counter tracks lot occupancy and
//   drives full/clear flags for the display logic.
// Ports:
//   clk          system clock (CLOCK_50 domain)
//   reset        synchronous, active-high reset
//   outer        [NUM_GATES] outer sensor per gate, 1 = beam blocked
//   inner        [NUM_GATES] inner sensor per gate, 1 = beam blocked
//   enter_pulse  [NUM_GATES] 1-cycle pulse per completed entry
//   exit_pulse   [NUM_GATES] 1-cycle pulse per completed exit
//   count        [CNT_W]     current occupancy, saturates at CAPACITY
//   full         count == CAPACITY
//   clear        count == 0
//   overflow     sticky: an entry was dropped at CAPACITY
//   underflow    sticky: an exit was dropped at 0
// Configuration macro:
//   PARKING_SYNC_EN  adds a 2-flop synchronizer on outer/inner (+2 cycles latency)
module parking_lot_multi_gate #(
  parameter  int NUM_GATES = 2,
  parameter  int CAPACITY  = 16,
  localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  output logic [NUM_GATES-1:0] enter_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 clear,
  output logic                 overflow,
  output logic                 underflow
);

  // Signed width wide enough for count plus/minus every gate firing at once.
  localparam int NW = CNT_W + $clog2(NUM_GATES + 1) + 1;
  localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE, S_E1, S_E2, S_E3, S_X1, S_X2, S_X3, S_WAIT
  } gate_state_t;

  logic [NUM_GATES-1:0] outer_s, inner_s;

`ifdef PARKING_SYNC_EN
  logic [NUM_GATES-1:0] outer_m, inner_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      outer_m <= '0;
      inner_m <= '0;
      outer_s <= '0;
      inner_s <= '0;
    end else begin
      outer_m <= outer;
      inner_m <= inner;
      outer_s <= outer_m;
      inner_s <= inner_m;
    end
  end
`else
  assign outer_s = outer;
  assign inner_s = inner;
`endif

  logic [NUM_GATES-1:0][1:0] pair;
  gate_state_t               state_q [NUM_GATES];
  gate_state_t               state_d [NUM_GATES];
  logic [NUM_GATES-1:0]      enter_d, exit_d;

  always_comb begin
    for (int g = 0; g < NUM_GATES; g++) begin
      pair[g] = {outer_s[g], inner_s[g]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < NUM_GATES; g++) begin
        state_q[g] <= S_IDLE;
      end
      enter_pulse <= '0;
      exit_pulse  <= '0;
    end else begin
      state_q     <= state_d;
      enter_pulse <= enter_d;
      exit_pulse  <= exit_d;
    end
  end

  // Entry walks outer->both->inner->clear, exit walks the reverse. Any
  // illegal jump parks the gate in S_WAIT until both beams are clear.
  always_comb begin
    enter_d = '0;
    exit_d  = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      state_d[g] = state_q[g];
      case (state_q[g])
        S_IDLE: case (pair[g])
          2'b10:   state_d[g] = S_E1;
          2'b01:   state_d[g] = S_X1;
          2'b11:   state_d[g] = S_WAIT;
          default: ;
        endcase
        S_E1: case (pair[g])
          2'b11:   state_d[g] = S_E2;
          2'b00:   state_d[g] = S_IDLE;
          2'b01:   state_d[g] = S_WAIT;
          default: ;
        endcase
        // Both beams dropping at once from the middle is ambiguous: hold in
        // S_WAIT for one more clear sample instead of guessing a direction.
        S_E2: case (pair[g])
          2'b01:   state_d[g] = S_E3;
          2'b10:   state_d[g] = S_E1;
          2'b00:   state_d[g] = S_WAIT;
          default: ;
        endcase
        S_E3: case (pair[g])
          2'b00: begin
            state_d[g] = S_IDLE;
            enter_d[g] = 1'b1;
          end
          2'b11:   state_d[g] = S_E2;
          2'b10:   state_d[g] = S_WAIT;
          default: ;
        endcase
        S_X1: case (pair[g])
          2'b11:   state_d[g] = S_X2;
          2'b00:   state_d[g] = S_IDLE;
          2'b10:   state_d[g] = S_WAIT;
          default: ;
        endcase
        S_X2: case (pair[g])
          2'b10:   state_d[g] = S_X3;
          2'b01:   state_d[g] = S_X1;
          2'b00:   state_d[g] = S_WAIT;
          default: ;
        endcase
        S_X3: case (pair[g])
          2'b00: begin
            state_d[g] = S_IDLE;
            exit_d[g]  = 1'b1;
          end
          2'b11:   state_d[g] = S_X2;
          2'b01:   state_d[g] = S_WAIT;
          default: ;
        endcase
        S_WAIT: begin
          if (pair[g] == 2'b00) state_d[g] = S_IDLE;
        end
        default: state_d[g] = S_IDLE;
      endcase
    end
  end

  // Simultaneous entries and exits net out before clamping, so a lot at
  // capacity with one entry and one exit in the same cycle stays put.
  logic signed [NW-1:0] net, sum;

  always_comb begin
    net = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      net = net + NW'(enter_pulse[g]) - NW'(exit_pulse[g]);
    end
    sum = NW'(count) + net;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sum[NW-1]) begin
      count     <= '0;
      underflow <= 1'b1;
    end else if (sum > CAP_S) begin
      count    <= CNT_W'(CAPACITY);
      overflow <= 1'b1;
    end else begin
      count <= sum[CNT_W-1:0];
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign clear = (count == '0);

endmodule

// File: tb/tb_parking_lot_multi_gate.sv
// tb/tb_parking_lot_multi_gate.sv - self-checking bench for parking_lot_multi_gate
module tb_parking_lot_multi_gate;

  localparam int NG  = 2;
  localparam int CAP = 4;
  localparam int CW  = $clog2(CAP + 1);
`ifdef PARKING_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic            CLOCK_50;
  logic            reset;
  logic [NG-1:0]   outer, inner;
  logic [NG-1:0]   enter_pulse, exit_pulse;
  logic [CW-1:0]   count;
  logic            full, clear, overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  parking_lot_multi_gate #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk         (CLOCK_50),
    .reset       (reset),
    .outer       (outer),
    .inner       (inner),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .count       (count),
    .full        (full),
    .clear       (clear),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each gate is viewed as a series of "runs": the non-clear samples between
  // two clear samples. A run counts as a pass if it starts at one beam, never
  // jumps directly between the single-beam symbols, and ends at the other
  // beam. A legal run that ends with both beams blocked swallows the next run.
  int         m_cnt;
  logic       m_ovf, m_unf;
  logic [1:0] m_en, m_ex;
  logic [1:0] r_first [NG];
  logic [1:0] r_last  [NG];
  int         r_len   [NG];
  bit         r_ok    [NG];
  bit         r_poison[NG];
  logic [1:0] d_o [2];
  logic [1:0] d_i [2];

  task automatic model_edge(input logic rst, input logic [1:0] o, input logic [1:0] i);
    logic [1:0] fo, fi, ne, nx, p;
    int t;
    if (rst) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0; m_en = 0; m_ex = 0;
      for (int g = 0; g < NG; g++) begin
        r_len[g] = 0; r_ok[g] = 1; r_poison[g] = 0; r_first[g] = 0; r_last[g] = 0;
      end
      d_o[0] = 0; d_o[1] = 0; d_i[0] = 0; d_i[1] = 0;
      return;
    end
    t = m_cnt + $countones(m_en) - $countones(m_ex);
    if (t > CAP)      begin m_cnt = CAP; m_ovf = 1; end
    else if (t < 0)   begin m_cnt = 0;   m_unf = 1; end
    else              m_cnt = t;
    fo = (SL == 0) ? o : d_o[1];
    fi = (SL == 0) ? i : d_i[1];
    ne = 0; nx = 0;
    for (int g = 0; g < NG; g++) begin
      p = {fo[g], fi[g]};
      if (p == 2'b00) begin
        if (r_poison[g]) r_poison[g] = 0;
        else if (r_len[g] > 0 && r_ok[g]) begin
          if (r_first[g] == 2'b10 && r_last[g] == 2'b01)      ne[g] = 1;
          else if (r_first[g] == 2'b01 && r_last[g] == 2'b10) nx[g] = 1;
          else if (r_last[g] == 2'b11)                        r_poison[g] = 1;
        end
        r_len[g] = 0;
        r_ok[g]  = 1;
      end else begin
        if (r_len[g] == 0) begin
          r_first[g] = p;
          r_ok[g]    = (p != 2'b11);
        end else if ((p ^ r_last[g]) == 2'b11) begin
          r_ok[g] = 0;
        end
        r_last[g] = p;
        r_len[g]++;
      end
    end
    m_en = ne; m_ex = nx;
    d_o[1] = d_o[0]; d_o[0] = o;
    d_i[1] = d_i[0]; d_i[0] = i;
  endtask

  function automatic logic [10:0] model_vec();
    return {m_en, m_ex, CW'(m_cnt), m_cnt == CAP, m_cnt == 0, m_ovf, m_unf};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {enter_pulse, exit_pulse, count, full, clear, overflow, underflow};
  endfunction

  task automatic step(input logic rst, input logic [1:0] o, input logic [1:0] i);
    reset = rst; outer = o; inner = i;
    @(posedge CLOCK_50);
    model_edge(rst, o, i);
    @(negedge CLOCK_50);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [1:0] o, i;
    logic [1:0] en, ex;
    int         cnt;
    logic       ovf, unf;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] obs[$];

  task automatic add(input logic rst, input logic [1:0] o, input logic [1:0] i,
                     input logic [1:0] en, input logic [1:0] ex, input int cnt);
    vec_t v;
    v.rst = rst; v.o = o; v.i = i; v.en = en; v.ex = ex; v.cnt = cnt;
    v.ovf = 0; v.unf = 0;
    tbl.push_back(v);
  endtask

  function automatic logic [10:0] exp_of(input vec_t v);
    return {v.en, v.ex, CW'(v.cnt), v.cnt == CAP, v.cnt == 0, v.ovf, v.unf};
  endfunction

  function automatic logic [1:0] sym(input int r);
    case (r)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  initial begin
    int pos [NG];
    int dir [NG];
    // outer/inner columns are {g1,g0}
    // reset, then g0 entry 10,11,01,00
    add(1, 2'b00, 2'b00, 0, 0, 0); add(1, 2'b00, 2'b00, 0, 0, 0); add(1, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b01, 2'b00, 0, 0, 0); add(0, 2'b01, 2'b01, 0, 0, 0); add(0, 2'b00, 2'b01, 0, 0, 0);
    add(0, 2'b00, 2'b00, 2'b01, 0, 0); add(0, 2'b00, 2'b00, 0, 0, 1);
    // second g0 entry -> count 2
    add(0, 2'b01, 2'b00, 0, 0, 1); add(0, 2'b01, 2'b01, 0, 0, 1); add(0, 2'b00, 2'b01, 0, 0, 1);
    add(0, 2'b00, 2'b00, 2'b01, 0, 1); add(0, 2'b00, 2'b00, 0, 0, 2);
    // g0 entry and g1 exit complete together
    add(0, 2'b01, 2'b10, 0, 0, 2); add(0, 2'b11, 2'b11, 0, 0, 2); add(0, 2'b10, 2'b01, 0, 0, 2);
    add(0, 2'b00, 2'b00, 2'b01, 2'b10, 2); add(0, 2'b00, 2'b00, 0, 0, 2);
    // g0 backs out, then illegal 10->01 goes through WAIT
    add(0, 2'b01, 2'b00, 0, 0, 2); add(0, 2'b01, 2'b01, 0, 0, 2); add(0, 2'b01, 2'b00, 0, 0, 2);
    add(0, 2'b00, 2'b00, 0, 0, 2); add(0, 2'b01, 2'b00, 0, 0, 2); add(0, 2'b00, 2'b01, 0, 0, 2);
    add(0, 2'b00, 2'b00, 0, 0, 2); add(0, 2'b00, 2'b00, 0, 0, 2);
    // reset while g0 sits in E2, then 01,00 is a silent abort
    add(0, 2'b01, 2'b00, 0, 0, 2); add(0, 2'b01, 2'b01, 0, 0, 2);
    add(1, 2'b01, 2'b01, 0, 0, 0); add(1, 2'b01, 2'b01, 0, 0, 0); add(1, 2'b01, 2'b01, 0, 0, 0);
    add(0, 2'b00, 2'b01, 0, 0, 0); add(0, 2'b00, 2'b00, 0, 0, 0); add(0, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0); add(0, 2'b00, 2'b00, 0, 0, 0);

    reset = 1; outer = 0; inner = 0;
    @(negedge CLOCK_50);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].rst, tbl[k].o, tbl[k].i);
      obs.push_back(dut_vec());
    end
    // With the synchronizer, outputs trail the table by SL cycles; skip rows
    // whose shifted reference would straddle a reset.
    for (int k = 0; k < tbl.size(); k++) begin
      int  j;
      bit  ok;
      j  = k - SL;
      ok = (j >= 0);
      for (int r = j + 1; r <= k; r++) if (r >= 0 && tbl[r].rst) ok = 0;
      if (ok) check($sformatf("tbl[%0d]", k), 32'(obs[k]), 32'(exp_of(tbl[j])));
    end

    // five entries on g1: saturate at CAP, fifth sets overflow
    for (int k = 1; k <= 5; k++) begin
      int seen, lat;
      step(0, 2'b10, 2'b00); step(0, 2'b10, 2'b10); step(0, 2'b00, 2'b10); step(0, 2'b00, 2'b00);
      seen = 0; lat = -1;
      for (int c = 0; c < 6; c++) begin
        if (enter_pulse[1]) begin seen++; if (lat < 0) lat = c; end
        step(0, 2'b00, 2'b00);
      end
      check($sformatf("sat%0d_pulses", k), 32'(seen), 32'd1);
      check($sformatf("sat%0d_latency", k), 32'(lat), 32'(SL));
      check($sformatf("sat%0d_count", k), 32'(count), 32'(k < CAP ? k : CAP));
      check($sformatf("sat%0d_full", k), 32'(full), 32'(k >= CAP));
      check($sformatf("sat%0d_overflow", k), 32'(overflow), 32'(k >= 5));
    end
    step(1, 2'b00, 2'b00);
    check("ovf_after_reset", 32'({overflow, full, clear}), 32'b001);

    // exit at count 0 is dropped and sets underflow
    begin
      int seen;
      step(1, 2'b00, 2'b00); step(1, 2'b00, 2'b00);
      step(0, 2'b00, 2'b01); step(0, 2'b01, 2'b01); step(0, 2'b01, 2'b00); step(0, 2'b00, 2'b00);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (exit_pulse[0]) seen++;
        step(0, 2'b00, 2'b00);
      end
      check("unf_pulses", 32'(seen), 32'd1);
      check("unf_count", 32'(count), 32'd0);
      check("unf_flags", 32'({underflow, overflow}), 32'b10);
      step(1, 2'b00, 2'b00);
      check("unf_after_reset", 32'({underflow, clear}), 32'b01);
    end

    // randomized ring walks per gate against the run-based model
    for (int g = 0; g < NG; g++) begin pos[g] = 0; dir[g] = 1; end
    step(1, 2'b00, 2'b00); step(1, 2'b00, 2'b00); step(1, 2'b00, 2'b00);
    for (int c = 0; c < 2500; c++) begin
      logic [1:0] o, i, s;
      logic       rst;
      int         x;
      for (int g = 0; g < NG; g++) begin
        x = $urandom_range(0, 15);
        if (x < 6)       ;
        else if (x < 11) pos[g] = (pos[g] + dir[g] + 4) % 4;
        else if (x < 14) pos[g] = (pos[g] - dir[g] + 4) % 4;
        else             pos[g] = $urandom_range(0, 3);
        if (pos[g] == 0 && $urandom_range(0, 19) == 0) dir[g] = -dir[g];
        s = sym(pos[g]);
        o[g] = s[1];
        i[g] = s[0];
      end
      rst = ($urandom_range(0, 299) == 0);
      step(rst, o, i);
      check($sformatf("rand[%0d]", c), 32'(dut_vec()), 32'(model_vec()));
    end

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
